// File: rtl/snow_pkg.sv
// Shared definitions for the 4-bit SNOW-style FSM: state encoding, INIT length and S-box table.
package snow_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int INIT_CYCLES_DEF = 32;

  // Packed table: element [i] is SBOX(i); the literal lists index 15 first.
  localparam logic [15:0][3:0] SBOX_TABLE = {
    4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
    4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
  };

endpackage

// File: rtl/snow_sbox4.sv
// Purely combinational 4-bit S-box lookup.
module snow_sbox4
  import snow_pkg::*;
(
  input  logic [3:0] a_i,
  output logic [3:0] y_o
);

  assign y_o = SBOX_TABLE[a_i];

endmodule

// File: rtl/snow_fsm_4.sv
// Control FSM and R1/R2 nonlinear mixer of a 16-stage 4-bit SNOW-style keystream generator.
module snow_fsm_4
  import snow_pkg::*;
#(
  parameter int INIT_CYCLES = INIT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] s0,
  input  logic [3:0] s5,
  input  logic [3:0] s15,
  input  logic       ks_ready,
  output logic       lfsr_enable,
  output logic       init_mode,
  output logic [3:0] fb_mix,
  output logic [3:0] ks_data,
  output logic       ks_valid,
  output logic       busy
);

  localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       r1_q, r1_d;
  logic [3:0]       r2_q, r2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ks_data_q, ks_data_d;
  logic             ks_valid_q, ks_valid_d;

  logic [3:0] f_w;
  logic [3:0] z_w;
  logic [3:0] sbox_r1_w;
  logic       en_w;

  snow_sbox4 u_sbox (
    .a_i (r1_q),
    .y_o (sbox_r1_w)
  );

  assign f_w = (s15 + r1_q) ^ r2_q;
  assign z_w = f_w ^ s0;

  // stop suppresses the shift in the cycle it is seen.
  always_comb begin
    en_w = 1'b0;
    if (!stop) begin
      unique case (state_q)
        ST_INIT: en_w = 1'b1;
        ST_RUN:  en_w = !ks_valid_q || ks_ready;
        default: en_w = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    r1_d       = r1_q;
    r2_d       = r2_q;
    cnt_d      = cnt_q;
    ks_data_d  = ks_data_q;
    ks_valid_d = ks_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_INIT;
          r1_d    = 4'h0;
          r2_d    = 4'h0;
          cnt_d   = '0;
        end
      end
      ST_INIT: begin
        if (stop) begin
          state_d    = ST_IDLE;
          ks_valid_d = 1'b0;
        end else begin
          r1_d  = r2_q + s5;
          r2_d  = sbox_r1_w;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d    = ST_IDLE;
          ks_valid_d = 1'b0;
        end else if (en_w) begin
          ks_data_d  = z_w;
          ks_valid_d = 1'b1;
          r1_d       = r2_q + s5;
          r2_d       = sbox_r1_w;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      r1_q       <= 4'h0;
      r2_q       <= 4'h0;
      cnt_q      <= '0;
      ks_data_q  <= 4'h0;
      ks_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      cnt_q      <= cnt_d;
      ks_data_q  <= ks_data_d;
      ks_valid_q <= ks_valid_d;
    end
  end

  assign lfsr_enable = en_w;
  assign init_mode   = (state_q == ST_INIT);
  assign busy        = (state_q != ST_IDLE);
  assign fb_mix      = f_w;
  assign ks_data     = ks_data_q;
  assign ks_valid    = ks_valid_q;

endmodule

// File: tb/tb_snow_fsm_4.sv
// Directed plus randomized bench for snow_fsm_4 against a cycle-level reference model.
module tb_snow_fsm_4;

  logic       clk = 1'b0;
  logic       reset, start, stop, ks_ready;
  logic [3:0] s0, s5, s15;
  logic       lfsr_enable, init_mode, ks_valid, busy;
  logic [3:0] fb_mix, ks_data;

  snow_fsm_4 #(.INIT_CYCLES(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .s0          (s0),
    .s5          (s5),
    .s15         (s15),
    .ks_ready    (ks_ready),
    .lfsr_enable (lfsr_enable),
    .init_mode   (init_mode),
    .fb_mix      (fb_mix),
    .ks_data     (ks_data),
    .ks_valid    (ks_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int init_seen;
  int sbox [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  // Reference model: mode 0 = idle, 1 = initialising, 2 = producing keystream.
  int m_mode, m_r1, m_r2, m_cnt, m_kd, m_kv;

  function automatic int m_f();
    return ((int'(s15) + m_r1) % 16) ^ m_r2;
  endfunction

  function automatic int m_en();
    if (stop) return 0;
    if (m_mode == 1) return 1;
    if (m_mode == 2) return (m_kv == 0 || ks_ready) ? 1 : 0;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    if (init_mode === 1'b1) init_seen++;
    chk("lfsr_enable", {7'd0, lfsr_enable}, 8'(m_en()));
    chk("init_mode",   {7'd0, init_mode},   8'(m_mode == 1));
    chk("busy",        {7'd0, busy},        8'(m_mode != 0));
    chk("fb_mix",      {4'd0, fb_mix},      8'(m_f()));
    chk("ks_data",     {4'd0, ks_data},     8'(m_kd));
    chk("ks_valid",    {7'd0, ks_valid},    8'(m_kv));
  endtask

  task automatic edge_step();
    int en, f, nr1, nr2;
    @(posedge clk);
    en  = m_en();
    f   = m_f();
    nr1 = (m_r2 + int'(s5)) % 16;
    nr2 = sbox[m_r1];
    if (reset) begin
      m_mode = 0; m_r1 = 0; m_r2 = 0; m_cnt = 0; m_kd = 0; m_kv = 0;
    end else if (m_mode == 0) begin
      if (start && !stop) begin
        m_mode = 1; m_r1 = 0; m_r2 = 0; m_cnt = 0;
      end
    end else if (stop) begin
      m_mode = 0; m_kv = 0;
    end else if (m_mode == 1) begin
      m_r1 = nr1; m_r2 = nr2;
      if (m_cnt == 31) m_mode = 2;
      m_cnt++;
    end else if (en != 0) begin
      m_kd = f ^ int'(s0); m_kv = 1; m_r1 = nr1; m_r2 = nr2;
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    edge_step();
  endtask

  task automatic rnd_s();
    s0  = 4'($urandom_range(0, 15));
    s5  = 4'($urandom_range(0, 15));
    s15 = 4'($urandom_range(0, 15));
  endtask

  logic [3:0] held;

  initial begin
    m_mode = 0; m_r1 = 0; m_r2 = 0; m_cnt = 0; m_kd = 0; m_kv = 0;
    init_seen = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; ks_ready = 1'b1;
    s0 = 4'h0; s5 = 4'h0; s15 = 4'h3;
    @(posedge clk); #1;
    edge_step();
    settle();
    chk("rst_ks_valid", {7'd0, ks_valid}, 8'd0);
    chk("rst_lfsr_en",  {7'd0, lfsr_enable}, 8'd0);
    chk("rst_fb_mix",   {4'd0, fb_mix}, 8'h3);
    edge_step();
    reset = 1'b0;
    cyc();

    // Start, then the first two INIT cycles with fixed taps.
    start = 1'b1;
    cyc();
    start = 1'b0; init_seen = 0;
    s15 = 4'h3; s5 = 4'h7;
    settle();
    chk("init0_fb_mix", {4'd0, fb_mix}, 8'h3);
    edge_step();
    s15 = 4'h0;
    settle();
    chk("init1_fb_mix", {4'd0, fb_mix}, 8'hB);
    edge_step();
    for (int i = 0; i < 30; i++) begin rnd_s(); cyc(); end
    settle();
    chk("run0_ks_valid", {7'd0, ks_valid}, 8'd0);
    chk("run0_lfsr_en",  {7'd0, lfsr_enable}, 8'd1);
    edge_step();
    settle();
    chk("run1_ks_valid", {7'd0, ks_valid}, 8'd1);
    chk("init_len", 8'(init_seen), 8'd32);
    edge_step();
    for (int i = 0; i < 5; i++) begin rnd_s(); cyc(); end

    // Backpressure hold.
    ks_ready = 1'b0;
    held = ks_data;
    for (int i = 0; i < 5; i++) begin
      rnd_s();
      settle();
      chk("bp_data", {4'd0, ks_data}, {4'd0, held});
      chk("bp_lfsr_en", {7'd0, lfsr_enable}, 8'd0);
      edge_step();
    end
    ks_ready = 1'b1;
    cyc();

    // Random handshake with ignored start requests.
    for (int i = 0; i < 200; i++) begin
      rnd_s();
      ks_ready = 1'($urandom_range(0, 1));
      start    = ($urandom_range(0, 7) == 0);
      cyc();
    end
    start = 1'b0; ks_ready = 1'b1;

    // stop at INIT cycle 10, then a full restart.
    stop = 1'b1; cyc(); stop = 1'b0; cyc();
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin rnd_s(); cyc(); end
    stop = 1'b1; cyc(); stop = 1'b0;
    settle();
    chk("stop_busy", {7'd0, busy}, 8'd0);
    chk("stop_ks_valid", {7'd0, ks_valid}, 8'd0);
    edge_step();
    start = 1'b1; cyc(); start = 1'b0; init_seen = 0;
    for (int i = 0; i < 36; i++) begin rnd_s(); cyc(); end
    chk("restart_init_len", 8'(init_seen), 8'd32);

    // reset at INIT cycle 10.
    stop = 1'b1; cyc(); stop = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin rnd_s(); cyc(); end
    reset = 1'b1; start = 1'b1; cyc(); reset = 1'b0; start = 1'b0;
    settle();
    chk("rst_mid_busy", {7'd0, busy}, 8'd0);
    chk("rst_mid_ks_valid", {7'd0, ks_valid}, 8'd0);
    edge_step();
    cyc();

    // start and stop together in IDLE.
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    settle();
    chk("start_stop_idle", {7'd0, busy}, 8'd0);
    edge_step();

    // Mixed random traffic with occasional stop, start and reset.
    for (int i = 0; i < 400; i++) begin
      rnd_s();
      ks_ready = 1'($urandom_range(0, 1));
      start    = ($urandom_range(0, 15) == 0);
      stop     = ($urandom_range(0, 63) == 0);
      reset    = ($urandom_range(0, 127) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/snow_fsm_4.md
SNOW_FSM_4 -- requirements
Module: snow_fsm_4

Interface
REQ-001 Parameter INIT_CYCLES, default 32: number of initialisation clocks before keystream output begins.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin initialisation; honoured only in IDLE.
REQ-005 stop  input  1  abort request; returns the block to IDLE from INIT or RUN.
REQ-006 s0  input  4  LFSR stage d0, the newest stage.
REQ-007 s5  input  4  LFSR stage d5.
REQ-008 s15  input  4  LFSR stage d15, the oldest stage.
REQ-009 lfsr_enable  output  1  shift-enable driven to the 16-stage 4-bit LFSR.
REQ-010 init_mode  output  1  high while in INIT; LFSR XORs fb_mix into its feedback.
REQ-011 fb_mix  output  4  FSM output F, used as the LFSR feedback mix during INIT.
REQ-012 ks_data  output  4  registered keystream nibble.
REQ-013 ks_valid  output  1  ks_data is valid.
REQ-014 ks_ready  input  1  consumer accepts ks_data when ks_valid and ks_ready are both high.
REQ-015 busy  output  1  high in INIT or RUN.

Function
REQ-016 Internal registers: R1[3:0], R2[3:0], cnt (wide enough for INIT_CYCLES-1), and a state register with states IDLE, INIT and RUN.
REQ-017 Combinational F = ((s15 + R1) mod 16) XOR R2; fb_mix = F at all times.
REQ-018 FSM step, taken whenever lfsr_enable = 1: R1 <= (R2 + s5) mod 16; R2 <= SBOX(R1).
REQ-019 SBOX, indexed 0..F: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
REQ-020 Keystream nibble z = F XOR s0.
REQ-021 IDLE: lfsr_enable=0; init_mode=0; R1 and R2 hold.
- start=1 -> INIT on the next edge, with R1<=0, R2<=0, cnt<=0.
REQ-022 INIT: lfsr_enable=1 and init_mode=1 on every cycle; cnt increments each cycle.
- When cnt==INIT_CYCLES-1 -> RUN on that edge.
- Result: exactly INIT_CYCLES enabled cycles.
REQ-023 RUN: lfsr_enable = (!ks_valid | ks_ready).
- When lfsr_enable=1: ks_data<=z, ks_valid<=1, FSM step taken.
- Otherwise ks_data, ks_valid, R1, R2 and the LFSR all hold.
REQ-024 Backpressure: while ks_valid=1 and ks_ready=0, ks_data is stable and no LFSR shift occurs.
REQ-025 Exactly one nibble is produced per accepted nibble; no loss, no duplication.
REQ-026 stop=1 in INIT or RUN -> IDLE on the next edge, with ks_valid<=0 and lfsr_enable=0 in that cycle.
- stop has priority over start and over the handshake.
REQ-027 start in INIT or RUN is ignored.
REQ-028 start and stop both high in IDLE: stay in IDLE.
REQ-029 lfsr_enable, init_mode and busy are combinational from state and handshake.
- ks_data and ks_valid are registered.

Reset
REQ-030 reset=1 at a clock edge forces state=IDLE, R1=0, R2=0, cnt=0, ks_data=0 and ks_valid=0.
- reset overrides start, stop and the handshake.
REQ-031 Outputs after reset: lfsr_enable=0, init_mode=0, busy=0, fb_mix = s15 (since R1=R2=0).
REQ-032 reset asserted mid-INIT or mid-RUN discards all progress; a new start is required to resume.

Structure
REQ-033 Shared package snow_pkg holds:
- the state enumeration (IDLE, INIT, RUN);
- the INIT_CYCLES default constant;
- the 16-entry SBOX constant table.
REQ-034 One sub-module, snow_sbox4 (4-bit in, 4-bit out, purely combinational), implements SBOX.
REQ-035 Target size is 120-400 lines of RTL; no memories; a single clock domain.

Verification
REQ-036 Reset with s15=3 -> ks_valid=0, lfsr_enable=0, fb_mix=3.
REQ-037 start pulse, then first INIT cycle with s15=3, s5=7 -> fb_mix=3; after the edge, R1=7, R2=C.
- Next cycle with s15=0 -> fb_mix = 7 XOR C = B.
REQ-038 start with ks_ready=1 throughout -> init_mode high for exactly 32 cycles.
- First ks_valid=1 appears one edge after entering RUN.
- lfsr_enable is then high every cycle.
REQ-039 In RUN with ks_valid=1, ks_ready held 0 for 5 cycles -> ks_data constant and lfsr_enable=0 all 5 cycles.
- On ks_ready=1, a new nibble is loaded on the next edge.
REQ-040 R1=2, R2=5, s15=9, s0=6 in RUN with ks_ready=1 -> ks_data = (B XOR 5) XOR 6 = 8 after the edge.
REQ-041 stop or reset asserted at INIT cycle 10 -> IDLE on the next edge, ks_valid=0, busy=0.
- A subsequent start repeats the full 32-cycle INIT.
